// File: rtl/regfile_zero_sb.sv
// Register file with hardwired zero register and pending-write scoreboard.
// Optional same-cycle write-through forwarding: define REGFILE_BYPASS_EN.
module regfile_zero_sb #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter bit HARDWIRE_ZERO = 1'b1,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [WIDTH-1:0]  rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  rdata_b,
   input  logic              alloc_en,
   input  logic [ADDR_W-1:0] alloc_addr,
   output logic              busy_a,
   output logic              busy_b,
   output logic              busy_any
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] sb_q;
   logic [DEPTH-1:0] sb_d;
   logic             wr_ok;

   always_comb begin
      wr_ok = we && !(HARDWIRE_ZERO && (waddr == '0));
      mem_d = mem_q;
      if (wr_ok) mem_d[waddr] = wdata;
      sb_d = sb_q;
      if (we) sb_d[waddr] = 1'b0;
      // alloc after clear: a new owner on the same edge wins
      if (alloc_en) sb_d[alloc_addr] = 1'b1;
      if (HARDWIRE_ZERO) sb_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         sb_q <= '0;
      end else begin
         mem_q <= mem_d;
         sb_q  <= sb_d;
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic byp_ok;
   // forwarding is gated by reset so outputs stay zero while it is held
   assign byp_ok = wr_ok && rst_n;
`endif

   always_comb begin
      rdata_a = mem_q[raddr_a];
      busy_a  = sb_q[raddr_a];
      if (HARDWIRE_ZERO && (raddr_a == '0)) rdata_a = '0;
`ifdef REGFILE_BYPASS_EN
      if (byp_ok && (waddr == raddr_a)) begin
         rdata_a = wdata;
         busy_a  = alloc_en && (alloc_addr == raddr_a);
      end
`endif
   end

   always_comb begin
      rdata_b = mem_q[raddr_b];
      busy_b  = sb_q[raddr_b];
      if (HARDWIRE_ZERO && (raddr_b == '0)) rdata_b = '0;
`ifdef REGFILE_BYPASS_EN
      if (byp_ok && (waddr == raddr_b)) begin
         rdata_b = wdata;
         busy_b  = alloc_en && (alloc_addr == raddr_b);
      end
`endif
   end

   assign busy_any = |sb_q;

endmodule

// File: tb/tb_regfile_zero_sb.sv
// Bench for regfile_zero_sb: vector table, corner sequences, random vs model.
// Also exercises a DEPTH=8 / WIDTH=16 instance.
module tb_regfile_zero_sb;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we, alloc_en;
   logic [4:0]  waddr, raddr_a, raddr_b, alloc_addr;
   logic [31:0] wdata, rdata_a, rdata_b;
   logic        busy_a, busy_b, busy_any;

   logic        we2, alloc_en2;
   logic [2:0]  waddr2, raddr_a2, raddr_b2, alloc_addr2;
   logic [15:0] wdata2, rdata_a2, rdata_b2;
   logic        busy_a2, busy_b2, busy_any2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_zero_sb dut (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .rdata_a(rdata_a),
      .raddr_b(raddr_b), .rdata_b(rdata_b),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr),
      .busy_a(busy_a), .busy_b(busy_b), .busy_any(busy_any)
   );

   regfile_zero_sb #(.WIDTH(16), .DEPTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .we(we2), .waddr(waddr2), .wdata(wdata2),
      .raddr_a(raddr_a2), .rdata_a(rdata_a2),
      .raddr_b(raddr_b2), .rdata_b(rdata_b2),
      .alloc_en(alloc_en2), .alloc_addr(alloc_addr2),
      .busy_a(busy_a2), .busy_b(busy_b2), .busy_any(busy_any2)
   );

   // reference model: architectural register values and pending flags
   logic [31:0] m_mem [32];
   logic        m_sb  [32];

   function automatic void m_clear();
      for (int i = 0; i < 32; i++) begin
         m_mem[i] = '0;
         m_sb[i]  = 1'b0;
      end
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 0) return '0;
      if (BYP && we && waddr == a) return wdata;
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (a == 0) return 1'b0;
      if (BYP && we && waddr == a) return alloc_en && alloc_addr == a;
      return m_sb[a];
   endfunction

   function automatic logic exp_any();
      logic r = 1'b0;
      for (int i = 0; i < 32; i++) r |= m_sb[i];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra,
                        input logic [4:0] rb, input logic al,
                        input logic [4:0] aa);
      we = w; waddr = wa; wdata = wd;
      raddr_a = ra; raddr_b = rb;
      alloc_en = al; alloc_addr = aa;
   endtask

   task automatic cyc();
      @(posedge clk);
      if (!rst_n) m_clear();
      else begin
         if (we && waddr != 0) m_mem[waddr] = wdata;
         if (we) m_sb[waddr] = 1'b0;
         if (alloc_en) m_sb[alloc_addr] = 1'b1;
         m_sb[0] = 1'b0;
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic        w;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra, rb;
      logic        al;
      logic [4:0]  aa;
      logic [31:0] ea, eb;
      logic        eba, ebb, eany;
   } vec_t;

   vec_t tbl [12];

   function automatic vec_t mk(
      input logic w, input logic [4:0] wa, input logic [31:0] wd,
      input logic [4:0] ra, input logic [4:0] rb,
      input logic al, input logic [4:0] aa,
      input logic [31:0] ea, input logic [31:0] eb,
      input logic eba, input logic ebb, input logic eany);
      vec_t v;
      v.w = w; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
      v.al = al; v.aa = aa; v.ea = ea; v.eb = eb;
      v.eba = eba; v.ebb = ebb; v.eany = eany;
      return v;
   endfunction

   localparam logic [31:0] K7 = 32'h12345678;

   initial begin
      tbl[0]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0,  0,  0, 0, 0);
      tbl[1]  = mk(0, 0, 0,            0, 0, 1, 0, 0,  0,  0, 0, 0);
      tbl[2]  = mk(0, 0, 0,            0, 7, 0, 0, 0,  K7, 0, 0, 0);
      tbl[3]  = mk(0, 0, 0,            9, 7, 1, 9, 0,  K7, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0,            9, 9, 0, 0, 0,  0,  1, 1, 1);
      tbl[5]  = mk(1, 9, 32'h55,       7, 3, 0, 0, K7, 0,  0, 0, 1);
      tbl[6]  = mk(0, 0, 0,            9, 9, 0, 0, 32'h55, 32'h55, 0, 0, 0);
      tbl[7]  = mk(1, 9, 32'h66,       7, 31, 1, 9, K7, 0, 0, 0, 0);
      tbl[8]  = mk(0, 0, 0,            9, 9, 0, 0, 32'h66, 32'h66, 1, 1, 1);
      tbl[9]  = mk(0, 0, 0,            9, 9, 1, 9, 32'h66, 32'h66, 1, 1, 1);
      tbl[10] = mk(1, 9, 32'h77,       7, 7, 0, 0, K7, K7, 0, 0, 1);
      tbl[11] = mk(0, 0, 0,            9, 9, 0, 0, 32'h77, 32'h77, 0, 0, 0);

      m_clear();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      we2 = 0; waddr2 = 0; wdata2 = 0; raddr_a2 = 0; raddr_b2 = 0;
      alloc_en2 = 0; alloc_addr2 = 0;
      #2;
      chk("reset_rdata_a", rdata_a, 0);
      chk("reset_busy_any", {31'b0, busy_any}, 0);
      chk("reset8_rdata_b", {16'b0, rdata_b2}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // write latency on both ports
      drive(1, 7, K7, 7, 7, 0, 0);
      #2;
      chk("lat_old_a", rdata_a, BYP ? K7 : 32'h0);
      chk("lat_old_b", rdata_b, BYP ? K7 : 32'h0);
      cyc();
      drive(0, 0, 0, 7, 7, 0, 0);
      #2;
      chk("lat_new_a", rdata_a, K7);
      chk("lat_new_b", rdata_b, K7);
      cyc();

      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb,
               tbl[i].al, tbl[i].aa);
         #2;
         chk($sformatf("tbl%0d_rdata_a", i), rdata_a, tbl[i].ea);
         chk($sformatf("tbl%0d_rdata_b", i), rdata_b, tbl[i].eb);
         chk($sformatf("tbl%0d_busy_a", i), {31'b0, busy_a}, {31'b0, tbl[i].eba});
         chk($sformatf("tbl%0d_busy_b", i), {31'b0, busy_b}, {31'b0, tbl[i].ebb});
         chk($sformatf("tbl%0d_busy_any", i), {31'b0, busy_any}, {31'b0, tbl[i].eany});
         cyc();
      end

      // back-to-back writes: reg31 on the wide build, reg7 on the small one
      for (int k = 1; k <= 4; k++) begin
         logic [31:0] prev;
         prev = (k == 1) ? 32'd0 : 32'(k - 1);
         drive(k <= 3, 31, 32'(k), 0, 31, 0, 0);
         we2 = (k <= 3); waddr2 = 3'd7; wdata2 = 16'(k); raddr_b2 = 3'd7;
         #2;
         chk($sformatf("b2b_%0d", k), rdata_b,
             (BYP && k <= 3) ? 32'(k) : prev);
         chk($sformatf("b2b8_%0d", k), {16'b0, rdata_b2},
             (BYP && k <= 3) ? 32'(k) : prev);
         cyc();
      end
      // small build: zero register ignores writes and allocs
      drive(0, 0, 0, 0, 0, 0, 0);
      we2 = 1; waddr2 = 0; wdata2 = 16'hFFFF; raddr_b2 = 0;
      alloc_en2 = 1; alloc_addr2 = 0;
      cyc();
      we2 = 0; alloc_en2 = 0; raddr_a2 = 0;
      #2;
      chk("zero8_rdata", {16'b0, rdata_a2}, 0);
      chk("zero8_busy", {30'b0, busy_a2, busy_any2}, 0);
      cyc();

      // forwarding corner
      drive(1, 3, 32'hA, 0, 3, 0, 0);
      cyc();
      drive(1, 3, 32'hB, 0, 3, 0, 0);
      #2;
      chk("byp_rdata_b", rdata_b, BYP ? 32'hB : 32'hA);
      chk("byp_busy_b", {31'b0, busy_b}, 0);
      cyc();
      drive(1, 3, 32'hC, 0, 3, 1, 3);
      #2;
      chk("byp_alloc_busy_b", {31'b0, busy_b}, {31'b0, BYP});
      cyc();

      // asynchronous reset mid-cycle
      drive(1, 5, 32'hDEADBEEF, 0, 0, 1, 12);
      cyc();
      drive(0, 0, 0, 5, 12, 0, 0);
      #2;
      chk("pre_rst_rdata_a", rdata_a, 32'hDEADBEEF);
      chk("pre_rst_busy_any", {31'b0, busy_any}, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_rdata_a", rdata_a, 0);
      chk("rst_busy_b", {31'b0, busy_b}, 0);
      chk("rst_busy_any", {31'b0, busy_any}, 0);
      drive(1, 5, 32'h1, 5, 5, 1, 5);
      cyc();
      #2;
      chk("rst_held_rdata_a", rdata_a, 0);
      chk("rst_held_busy_a", {31'b0, busy_a}, 0);
      rst_n = 1'b1;
      drive(0, 0, 0, 5, 5, 0, 0);
      #2;
      chk("post_rst_rdata_a", rdata_a, 0);
      chk("post_rst_busy_any", {31'b0, busy_any}, 0);
      cyc();

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
               5'($urandom), 5'($urandom),
               1'($urandom_range(0, 2) == 0), 5'($urandom));
         if ((n % 7) == 0) raddr_b = waddr;
         if ((n % 11) == 0) alloc_addr = raddr_a;
         #2;
         chk("rnd_rdata_a", rdata_a, exp_rd(raddr_a));
         chk("rnd_rdata_b", rdata_b, exp_rd(raddr_b));
         chk("rnd_busy_a", {31'b0, busy_a}, {31'b0, exp_busy(raddr_a)});
         chk("rnd_busy_b", {31'b0, busy_b}, {31'b0, exp_busy(raddr_b)});
         chk("rnd_busy_any", {31'b0, busy_any}, {31'b0, exp_any()});
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
